muldiv_seq: RTL
===============

# muldiv_seq

Iterative multiply/divide sequencer with HI/LO registers for the MIPS execute stage. It accepts the two operands produced by the ALU source mux (rs in `src_a`, rt in `src_b`) and runs MULT/MULTU/DIV/DIVU as a WIDTH-cycle shift-add / restoring-divide loop, then one sign-fix cycle. It also executes MTHI/MTLO. The hazard unit uses `busy` to stall dependent instructions.

## Interface
- WIDTH, 32 (`WORD_SIZE`), operand/result width; even, >= 4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored (no effect)
- src_a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- src_b  in  WIDTH  rt operand (multiplier / divisor)
- flush  in  1  abort in-flight op (pipeline flush)
- busy  out  1  high in RUN and FIX
- done  out  1  one-cycle pulse when HI/LO updated by mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX. Reset: state IDLE, hi=lo=0, busy=0, done=0, counter=0.
- IDLE + start + mul/div op:
  - latch op;
  - for signed ops latch |src_a| and |src_b| as unsigned WIDTH-bit magnitudes, plus sign flags; unsigned ops latch operands as given;
  - counter=WIDTH-1; go to RUN.
- IDLE + start + MTHI/MTLO: hi (or lo) <= src_a at that edge; stay IDLE; no busy, no done.
- RUN: one iteration per cycle, MSB/LSB order free; internal 2*WIDTH accumulator. Counter decrements; at counter==0 go to FIX.
- FIX applies the sign correction, writes hi/lo, returns to IDLE and asserts done for the following cycle.
  - Multiply: {hi,lo} = product; negate the 2*WIDTH product if signed and signs differ.
  - Divide: lo = quotient, hi = remainder.
    - Signed: quotient is negated if signs differ; remainder takes the dividend's sign. Truncation toward zero.
    - Divisor zero (any div op): lo = all ones, hi = src_a as latched at accept (original value, no abs); no sign fix.
    - Signed MIN_INT / -1: lo = MIN_INT (1 followed by WIDTH-1 zeros), hi = 0. This falls out of the unsigned magnitude path; no trap.
- Overflow and width: all internal arithmetic is 2*WIDTH+1 bits max; results truncate to exactly WIDTH per register.
- start while busy: ignored, not queued. The hazard unit must hold the instruction.
- flush:
  - In RUN/FIX: go to IDLE next edge; hi/lo unchanged; no done.
  - In IDLE: start in the same cycle is ignored, including MTHI/MTLO.
- Priority: rst > flush > FIX completion > start.
- rst mid-operation: returns to reset values at the next edge; partial result discarded.

## Timing
- Accept edge E0 (IDLE, start=1). busy=1 in cycles after E0 through E(WIDTH+1), i.e. WIDTH+1 cycles.
- hi/lo update at edge E(WIDTH+1); done=1 and busy=0 in the cycle after E(WIDTH+1).
- A new start is accepted in that same done cycle, giving back-to-back throughput of one op per WIDTH+2 cycles.
- MTHI/MTLO latency: 1 edge; the value is visible on hi/lo in the next cycle.
- Operands are sampled only at E0; changes to src_a/src_b during RUN have no effect.
- done never asserts twice per op and never asserts together with busy.

## Test plan
- MULTU 0xFFFFFFFF*0xFFFFFFFF, WIDTH=32 -> busy for exactly 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A on consecutive cycles -> each visible the next cycle; busy and done stay 0.
- MULT started, with start pulsed again at cycle 5 carrying different operands -> second start ignored; flush at cycle 10 -> IDLE next cycle, hi/lo keep old values, no done.
- rst asserted mid-DIV -> next cycle hi=lo=0, busy=0; a fresh DIVU 100/7 then yields lo=14, hi=2 with normal latency.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Shift-add multiply / restoring divide, one bit per cycle, then a sign-fix cycle.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;          // bit1: divide, bit0: unsigned
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] raw_a_q, raw_a_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d, done_d;

    logic             acc_signed;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    div_shift;
    logic [WIDTH:0]   div_trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opnd_q  <= '0;
            raw_a_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            opnd_q  <= opnd_d;
            raw_a_q <= raw_a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi      <= hi_d;
            lo      <= lo_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, iteration step and result write-back
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        opnd_d  = opnd_q;
        raw_a_d = raw_a_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi;
        lo_d    = lo;
        done_d  = 1'b0;

        acc_signed = ~op[0];
        mag_a      = (acc_signed && src_a[WIDTH-1]) ? WIDTH'(-src_a) : src_a;
        mag_b      = (acc_signed && src_b[WIDTH-1]) ? WIDTH'(-src_b) : src_b;

        mul_sum   = acc_q[AW-1:WIDTH] + {1'b0, opnd_q};
        div_shift = {acc_q[AW-2:0], 1'b0};
        div_trial = div_shift[AW-1:WIDTH] - {1'b0, opnd_q};
        prod      = acc_q[2*WIDTH-1:0];
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        op_d    = op[1:0];
                        neg_a_d = acc_signed & src_a[WIDTH-1];
                        neg_b_d = acc_signed & src_b[WIDTH-1];
                        raw_a_d = src_a;
                        opnd_d  = op[1] ? mag_b : mag_a;
                        acc_d   = {{(WIDTH+1){1'b0}}, (op[1] ? mag_a : mag_b)};
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = S_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (op == OP_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    // Restoring divide: keep the trial difference when non-negative
                    acc_d = div_trial[WIDTH] ? div_shift
                                             : {div_trial, div_shift[WIDTH-1:1], 1'b1};
                end else begin
                    acc_d = acc_q[0] ? {1'b0, mul_sum, acc_q[WIDTH-1:1]}
                                     : {1'b0, acc_q[AW-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? (2*WIDTH)'(-prod) : prod;
                end else if (opnd_q == '0) begin
                    lo_d = '1;
                    hi_d = raw_a_q;
                end else begin
                    lo_d = (neg_a_q ^ neg_b_q) ? WIDTH'(-quo) : quo;
                    hi_d = neg_a_q ? WIDTH'(-rem) : rem;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush outranks completion and any start, including MTHI/MTLO
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi;
            lo_d    = lo;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule
